// File: rtl/io_bridge.sv
// io_bridge: decodes core bus accesses to DRAM, LEDs, switches and a scanned 8-digit seven-segment display.
// Optional free-running TIMER register at 0xFFFF_F020 enabled by IO_BRIDGE_TIMER_EN.
module io_bridge #(
  parameter int DRAM_AW  = 16,
  parameter int SCAN_DIV = 20000
) (
  input  logic               cpu_clk,
  input  logic               cpu_rst,
  input  logic [31:0]        Bus_addr,
  input  logic               Bus_wen,
  input  logic [31:0]        Bus_wdata,
  output logic [31:0]        Bus_rdata,
  output logic [DRAM_AW-3:0] dram_addr,
  output logic               dram_we,
  output logic [31:0]        dram_wdata,
  input  logic [31:0]        dram_rdata,
  input  logic [23:0]        sw,
  output logic [23:0]        led,
  output logic [7:0]         seg_en,
  output logic [7:0]         seg_dig
);
  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [7:0] HEX [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                      8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
  logic [29:0]   wa;
  logic          in_dram, sel_seg, sel_led, sel_sw, term;
  logic [23:0]   led_q, led_d, sw_meta_q, sw_sync_q;
  logic [31:0]   disp_q, disp_d, tmr_rd;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [3:0]    nib;
  assign wa      = Bus_addr[31:2];
  assign in_dram = Bus_addr < 32'hFFFF_F000;
  assign sel_seg = wa == 30'h3FFF_FC00;
  assign sel_led = wa == 30'h3FFF_FC18;
  assign sel_sw  = wa == 30'h3FFF_FC1C;
  assign dram_addr  = Bus_addr[DRAM_AW-1:2];
  assign dram_wdata = Bus_wdata;
  assign dram_we    = Bus_wen && in_dram;
  assign led_d  = (Bus_wen && sel_led) ? Bus_wdata[23:0] : led_q;
  assign disp_d = (Bus_wen && sel_seg) ? Bus_wdata : disp_q;
  assign term   = cnt_q == CW'(SCAN_DIV - 1);
  assign cnt_d  = term ? '0 : cnt_q + CW'(1);
  assign idx_d  = term ? idx_q + 3'd1 : idx_q;
  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      led_q     <= '0;
      sw_meta_q <= '0;
      sw_sync_q <= '0;
      disp_q    <= '0;
      cnt_q     <= '0;
      idx_q     <= '0;
    end else begin
      led_q     <= led_d;
      sw_meta_q <= sw;
      sw_sync_q <= sw_meta_q;
      disp_q    <= disp_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
    end
  end
`ifdef IO_BRIDGE_TIMER_EN
  logic        sel_tmr;
  logic [31:0] tmr_q, tmr_d;
  assign sel_tmr = wa == 30'h3FFF_FC08;
  // A bus write takes priority over the free-running increment
  assign tmr_d   = (Bus_wen && sel_tmr) ? Bus_wdata : tmr_q + 32'd1;
  assign tmr_rd  = sel_tmr ? tmr_q : '0;
  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) tmr_q <= '0;
    else         tmr_q <= tmr_d;
  end
`else
  assign tmr_rd = '0;
`endif
  assign nib       = disp_q[{idx_q, 2'b00} +: 4];
  assign led       = led_q;
  assign seg_en    = ~(8'b1 << idx_q);
  assign seg_dig   = HEX[nib];
  assign Bus_rdata = in_dram ? dram_rdata :
                     sel_seg ? disp_q :
                     sel_led ? {8'h0, led_q} :
                     sel_sw  ? {8'h0, sw_sync_q} : tmr_rd;
endmodule

// File: tb/tb_io_bridge.sv
// tb_io_bridge: directed self-checking bench for io_bridge with SCAN_DIV=4, DRAM_AW=16.
module tb_io_bridge;
  logic        cpu_clk = 0, cpu_rst = 1, Bus_wen = 0, dram_we;
  logic [31:0] Bus_addr = 0, Bus_wdata = 0, Bus_rdata, dram_wdata, dram_rdata = 32'hDEAD_BEEF;
  logic [13:0] dram_addr;
  logic [23:0] sw = 0, led;
  logic [7:0]  seg_en, seg_dig;
  int n_cmp = 0, n_err = 0;
  localparam logic [7:0] HEX_T [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
  localparam logic [7:0] EN_T [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
  io_bridge #(.DRAM_AW(16), .SCAN_DIV(4)) dut (
    .cpu_clk(cpu_clk), .cpu_rst(cpu_rst), .Bus_addr(Bus_addr), .Bus_wen(Bus_wen),
    .Bus_wdata(Bus_wdata), .Bus_rdata(Bus_rdata), .dram_addr(dram_addr), .dram_we(dram_we),
    .dram_wdata(dram_wdata), .dram_rdata(dram_rdata), .sw(sw), .led(led),
    .seg_en(seg_en), .seg_dig(seg_dig)
  );
  always #5 cpu_clk = ~cpu_clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge cpu_clk);
    #1;
  endtask
  task automatic bus(input logic [31:0] a, input logic w, input logic [31:0] d);
    Bus_addr = a; Bus_wen = w; Bus_wdata = d; #1;
  endtask
  initial begin
    bus(32'h0000_0010, 1, 32'h55);
    check("dram_we_in_reset", {31'b0, dram_we}, 1);
    bus(32'hFFFF_F060, 0, 0);
    tick; tick;
    cpu_rst = 0;
    #1;
    check("rst_seg_en", {24'b0, seg_en}, 32'hFE);
    check("rst_seg_dig", {24'b0, seg_dig}, 32'hC0);
    check("rst_led", {8'b0, led}, 0);
    check("rst_rd_led", Bus_rdata, 0);
    tick;
    bus(32'h0000_0010, 1, 32'h0000_1234);
    check("dram_we", {31'b0, dram_we}, 1);
    check("dram_addr", {18'b0, dram_addr}, 4);
    check("dram_wdata", dram_wdata, 32'h0000_1234);
    check("dram_rd", Bus_rdata, 32'hDEAD_BEEF);
    bus(32'hFFFF_EFFC, 1, 0);
    check("dram_top_we", {31'b0, dram_we}, 1);
    bus(32'hFFFF_F060, 1, 32'hFFA5_A5A5);
    check("led_dram_we", {31'b0, dram_we}, 0);
    tick;
    Bus_wen = 0;
    check("led_out", {8'b0, led}, 32'hA5A5A5);
    check("led_rd", Bus_rdata, 32'h00A5_A5A5);
    bus(32'hFFFF_F063, 0, 0);
    check("led_alias", Bus_rdata, 32'h00A5_A5A5);
    bus(32'hFFFF_F070, 0, 0);
    sw = 24'h123456;
    #1;
    check("sw_0", Bus_rdata, 0);
    tick;
    check("sw_1", Bus_rdata, 0);
    tick;
    check("sw_2", Bus_rdata, 32'h0012_3456);
    bus(32'hFFFF_F070, 1, 32'h00FF_FFFF);
    check("sw_wr_we", {31'b0, dram_we}, 0);
    tick;
    bus(32'hFFFF_F070, 0, 0);
    check("sw_wr_ign", Bus_rdata, 32'h0012_3456);
    bus(32'hFFFF_F044, 0, 0);
    check("unmap_rd", Bus_rdata, 0);
    bus(32'hFFFF_F044, 1, 32'h0011_2233);
    check("unmap_we", {31'b0, dram_we}, 0);
    tick;
    bus(32'hFFFF_F044, 0, 0);
    check("unmap_rd2", Bus_rdata, 0);
    check("unmap_led", {8'b0, led}, 32'hA5A5A5);
    bus(32'hFFFF_F000, 0, 0);
    check("unmap_seg", Bus_rdata, 0);
`ifdef IO_BRIDGE_TIMER_EN
    bus(32'hFFFF_F020, 1, 32'hFFFF_FFFE);
    tick;
    Bus_wen = 0;
    check("tmr_0", Bus_rdata, 32'hFFFF_FFFE);
    tick;
    check("tmr_1", Bus_rdata, 32'hFFFF_FFFF);
    tick;
    check("tmr_wrap", Bus_rdata, 0);
    tick; tick;
    check("tmr_run", Bus_rdata, 2);
    cpu_rst = 1;
    #1;
    check("tmr_rst", Bus_rdata, 0);
    cpu_rst = 0;
`else
    bus(32'hFFFF_F020, 1, 32'h1234_5678);
    tick;
    Bus_wen = 0;
    check("tmr_off", Bus_rdata, 0);
`endif
    tick;
    cpu_rst = 1;
    #1;
    cpu_rst = 0;
    check("rst_led2", {8'b0, led}, 0);
    bus(32'hFFFF_F000, 1, 32'h8765_4321);
    check("scan_en0", {24'b0, seg_en}, 32'hFE);
    for (int j = 1; j <= 32; j++) begin
      tick;
      Bus_wen = 0;
      check($sformatf("scan_en%0d", j), {24'b0, seg_en}, {24'b0, EN_T[(j / 4) % 8]});
      check($sformatf("scan_dig%0d", j), {24'b0, seg_dig}, {24'b0, HEX_T[(j / 4) % 8 + 1]});
    end
    check("seg_rd", Bus_rdata, 32'h8765_4321);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
